// File: rtl/inst_mem_pkg.sv
// inst_mem_pkg: shared definitions for the instruction memory loader.
//   ld_state_t  : loader FSM states (IDLE / LOAD / DONE / ERR)
//   HALT_WORD   : terminating word of a program image
//   NOP_WORD    : all-zero instruction
//   BOOT_IMAGE  : halt-terminated program used when INST_MEM_BOOT_IMAGE_EN is defined
//   BOOT_LEN    : number of words in BOOT_IMAGE
package inst_mem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_DONE = 2'd2,
    ST_ERR  = 2'd3
  } ld_state_t;

  localparam logic [31:0] HALT_WORD = 32'hFFFF_FFFF;
  localparam logic [31:0] NOP_WORD  = 32'h0000_0000;

  localparam int BOOT_LEN = 4;
  localparam logic [31:0] BOOT_IMAGE [BOOT_LEN] = '{
    32'h2001_0014,
    32'h0C00_000D,
    32'h0000_0000,
    32'hFFFF_FFFF
  };

endpackage

// File: rtl/inst_mem_loader_if.sv
// inst_mem_loader_if: loader byte stream plus fetch port of the instruction memory.
//   master : byte source / core side (drives ld_valid, ld_byte, ld_clear, fetch_en, fetch_addr)
//   slave  : the instruction memory (drives ld_ready, ld_done, ld_err, fetch_inst, fetch_valid)
interface inst_mem_loader_if #(
  parameter int WIDTH  = 32,
  parameter int ADDR_W = 8
);

  logic              ld_valid;
  logic              ld_ready;
  logic [7:0]        ld_byte;
  logic              ld_clear;
  logic              ld_done;
  logic              ld_err;
  logic              fetch_en;
  logic [ADDR_W-1:0] fetch_addr;
  logic [WIDTH-1:0]  fetch_inst;
  logic              fetch_valid;

  modport master (
    output ld_valid, ld_byte, ld_clear, fetch_en, fetch_addr,
    input  ld_ready, ld_done, ld_err, fetch_inst, fetch_valid
  );

  modport slave (
    input  ld_valid, ld_byte, ld_clear, fetch_en, fetch_addr,
    output ld_ready, ld_done, ld_err, fetch_inst, fetch_valid
  );

endinterface

// File: rtl/inst_mem_ram.sv
// inst_mem_ram: DEPTH x WIDTH storage, one synchronous write port and one
// synchronous (registered) read port.
//   clk          : clock
//   we/waddr/wdata : write port, written on the rising edge
//   re/raddr     : read request; rdata updates on the edge where re=1, holds otherwise
// Configuration macro: INST_MEM_BOOT_IMAGE_EN -- when defined, the array powers
// up holding BOOT_IMAGE (remaining words hold the halt word).
module inst_mem_ram #(
  parameter int DEPTH  = 256,
  parameter int WIDTH  = 32,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [WIDTH-1:0]  rdata
);

  typedef logic [WIDTH-1:0] mem_t [DEPTH];

`ifdef INST_MEM_BOOT_IMAGE_EN
  import inst_mem_pkg::*;

  function automatic mem_t boot_fill();
    mem_t m;
    for (int i = 0; i < DEPTH; i++) begin
      if (i < BOOT_LEN) m[i] = WIDTH'(BOOT_IMAGE[i]);
      else              m[i] = '1;
    end
    return m;
  endfunction

  mem_t mem = boot_fill();
`else
  mem_t mem;
`endif

  logic [WIDTH-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Read register has no reset so the array maps onto block RAM.
  always_ff @(posedge clk) begin
    if (re) rdata_q <= mem[raddr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/inst_mem_loader.sv
// inst_mem_loader: RAM-backed instruction memory filled by a byte-stream loader.
//   clk, rst   : clock, asynchronous active-high reset
//   bus.ld_*   : MSB-first byte stream; the load ends at an all-ones (halt) word
//                (ld_done) or when DEPTH words fill without one (ld_err).
//                ld_clear re-arms the loader; memory contents are kept.
//   bus.fetch_*: one-cycle-latency read port, live only once the load is done.
// Configuration macro: INST_MEM_BOOT_IMAGE_EN -- memory starts with BOOT_IMAGE
// and reset lands in DONE so the core can run without a load.
module inst_mem_loader
  import inst_mem_pkg::*;
#(
  parameter int DEPTH  = 256,
  parameter int WIDTH  = 32,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input logic               clk,
  input logic               rst,
  inst_mem_loader_if.slave  bus
);

  localparam int BYTES = WIDTH / 8;
  localparam int CNT_W = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam logic [CNT_W-1:0]  LAST_CNT  = CNT_W'(BYTES - 1);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W:0]   DEPTH_EXT = (ADDR_W + 1)'(DEPTH);

`ifdef INST_MEM_BOOT_IMAGE_EN
  localparam ld_state_t RST_STATE = ST_DONE;
  localparam logic      RST_DONE  = 1'b1;
`else
  localparam ld_state_t RST_STATE = ST_IDLE;
  localparam logic      RST_DONE  = 1'b0;
`endif

  ld_state_t         state_q, state_d;
  logic [ADDR_W-1:0] wptr_q, wptr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0]  asm_q, asm_d;
  logic              ld_ready_q, ld_ready_d;
  logic              ld_done_q, ld_done_d;
  logic              ld_err_q, ld_err_d;
  logic              fetch_valid_q, fetch_valid_d;
  logic              fetch_oob_q, fetch_oob_d;

  logic              byte_acc;
  logic              word_last;
  logic [WIDTH-1:0]  word_full;
  logic              mem_we;
  logic              rd_en;
  logic [WIDTH-1:0]  rd_data;

  always_comb begin
    // A byte arriving with ld_clear is dropped.
    byte_acc  = bus.ld_valid && ld_ready_q && !bus.ld_clear &&
                ((state_q == ST_IDLE) || (state_q == ST_LOAD));
    word_full = (asm_q << 8) | WIDTH'(bus.ld_byte);
    word_last = (cnt_q == LAST_CNT);
    // The word is written on the same edge that accepts its last byte.
    mem_we    = byte_acc && word_last;

    state_d = state_q;
    wptr_d  = wptr_q;
    cnt_d   = cnt_q;
    asm_d   = asm_q;

    if (bus.ld_clear) begin
      state_d = ST_IDLE;
      wptr_d  = '0;
      cnt_d   = '0;
      asm_d   = '0;
    end else if (byte_acc) begin
      state_d = ST_LOAD;
      if (word_last) begin
        cnt_d  = '0;
        asm_d  = '0;
        wptr_d = wptr_q + ADDR_W'(1);
        // Halt has priority: a halt word in the last slot still completes.
        if (word_full == '1)             state_d = ST_DONE;
        else if (wptr_q == LAST_ADDR)    state_d = ST_ERR;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
        asm_d = word_full;
      end
    end

    // Status flags follow the next state so they appear one cycle after the edge.
    ld_ready_d = (state_d == ST_IDLE) || (state_d == ST_LOAD);
    ld_done_d  = (state_d == ST_DONE);
    ld_err_d   = (state_d == ST_ERR);

    // A clear leaves DONE on this edge, so a fetch issued with it is not honoured.
    fetch_valid_d = bus.fetch_en && (state_q == ST_DONE) && !bus.ld_clear;
    fetch_oob_d   = ({1'b0, bus.fetch_addr} >= DEPTH_EXT);
    rd_en         = fetch_valid_d && !fetch_oob_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= RST_STATE;
      wptr_q        <= '0;
      cnt_q         <= '0;
      asm_q         <= '0;
      ld_ready_q    <= 1'b0;
      ld_done_q     <= RST_DONE;
      ld_err_q      <= 1'b0;
      fetch_valid_q <= 1'b0;
      fetch_oob_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      wptr_q        <= wptr_d;
      cnt_q         <= cnt_d;
      asm_q         <= asm_d;
      ld_ready_q    <= ld_ready_d;
      ld_done_q     <= ld_done_d;
      ld_err_q      <= ld_err_d;
      fetch_valid_q <= fetch_valid_d;
      fetch_oob_q   <= fetch_oob_d;
    end
  end

  inst_mem_ram #(
    .DEPTH  (DEPTH),
    .WIDTH  (WIDTH),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk   (clk),
    .we    (mem_we),
    .waddr (wptr_q),
    .wdata (word_full),
    .re    (rd_en),
    .raddr (bus.fetch_addr),
    .rdata (rd_data)
  );

  assign bus.ld_ready    = ld_ready_q;
  assign bus.ld_done     = ld_done_q;
  assign bus.ld_err      = ld_err_q;
  assign bus.fetch_valid = fetch_valid_q;
  // RAM output is stale when no valid fetch is pending, so it is masked to zero;
  // out-of-range addresses read as halt.
  assign bus.fetch_inst  = !fetch_valid_q ? '0 : (fetch_oob_q ? '1 : rd_data);

endmodule
